// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Package  : key_pkg
// Brief    : Shared constants, event encoding and width helpers for the keypad
//            debouncer and its downstream consumers.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

    localparam int KEY_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_REPEAT  = 2'd3
    } key_evt_e;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One key channel: 2-FF sync, tick-sampled stability filter,
//            registered press/release pulses and auto-repeat generator.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int STABLE_N     = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 1,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_key,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int              c_DW         = clog2_min1(STABLE_N + 1);
    localparam logic [c_DW-1:0] c_DIS_LAST   = c_DW'(STABLE_N - 1);
    localparam logic            c_IDLE_RAW   = (ACTIVE_LOW != 0);

    logic [1:0]      r_sync;
    logic            w_sample;
    logic            r_level;
    logic            r_level_d;
    logic [c_DW-1:0] r_dis_cnt;
    logic            w_level_nxt;
    logic [c_DW-1:0] w_dis_nxt;
    logic            r_press;
    logic            r_release;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= {2{c_IDLE_RAW}};
        end else begin
            r_sync <= {r_sync[0], i_key};
        end
    end

    assign w_sample = r_sync[1] ^ c_IDLE_RAW;

    always_comb begin
        w_level_nxt = r_level;
        w_dis_nxt   = r_dis_cnt;
        if (i_tick) begin
            if (w_sample == r_level) begin
                w_dis_nxt = '0;
            end else if (r_dis_cnt == c_DIS_LAST) begin
                w_level_nxt = w_sample;
                w_dis_nxt   = '0;
            end else begin
                w_dis_nxt = r_dis_cnt + c_DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_dis_cnt <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_level_d <= r_level;
            r_dis_cnt <= w_dis_nxt;
            r_press   <= r_level & ~r_level_d;
            r_release <= ~r_level & r_level_d;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    generate
        if (REPEAT_EN != 0) begin : g_rep
            localparam int              c_HW          = clog2_min1(HOLD_TICKS + 1);
            localparam logic [c_HW-1:0] c_HOLD_LAST   = c_HW'(HOLD_TICKS - 1);
            localparam logic [c_HW-1:0] c_HOLD_RELOAD = c_HW'(HOLD_TICKS - REPEAT_TICKS);

            logic [c_HW-1:0] r_hold_cnt;
            logic            r_rep_evt;
            logic            r_repeat;

            // The event is delayed one extra clk so repeats line up with the press pulse timing.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_hold_cnt <= '0;
                    r_rep_evt  <= 1'b0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_rep_evt <= 1'b0;
                    r_repeat  <= r_rep_evt;
                    if (!w_level_nxt) begin
                        r_hold_cnt <= '0;
                    end else if (i_tick && r_level) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_hold_cnt <= c_HOLD_RELOAD;
                            r_rep_evt  <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_HW'(1);
                        end
                    end
                end
            end

            assign o_repeat = r_repeat;
        end else begin : g_no_rep
            assign o_repeat = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel keypad debouncer with shared sample tick, priority key
//            code and multi-press flag.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS       = KEY_N_DEFAULT,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_N     = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 1,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_KEYS-1:0]             key_in,
    output logic [N_KEYS-1:0]             key_level,
    output logic [N_KEYS-1:0]             press_pulse,
    output logic [N_KEYS-1:0]             release_pulse,
    output logic [N_KEYS-1:0]             repeat_pulse,
    output logic                          key_valid,
    output logic [clog2_min1(N_KEYS)-1:0] key_code,
    output logic                          multi_press
);

    localparam int              c_TW        = clog2_min1(TICK_DIV);
    localparam int              c_CW        = clog2_min1(N_KEYS);
    localparam int              c_PW        = clog2_min1(N_KEYS + 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

    logic [c_TW-1:0]   r_tick_cnt;
    logic              w_tick;
    logic [N_KEYS-1:0] w_evt;
    logic [c_PW-1:0]   w_pop;
    logic              r_multi;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .STABLE_N     (STABLE_N),
                .ACTIVE_LOW   (ACTIVE_LOW),
                .REPEAT_EN    (REPEAT_EN),
                .HOLD_TICKS   (HOLD_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS)
            ) u_ch (
                .clk       (clk),
                .rstn      (rstn),
                .i_key     (key_in[gi]),
                .i_tick    (w_tick),
                .o_level   (key_level[gi]),
                .o_press   (press_pulse[gi]),
                .o_release (release_pulse[gi]),
                .o_repeat  (repeat_pulse[gi])
            );
        end
    endgenerate

    assign w_evt     = press_pulse | repeat_pulse;
    assign key_valid = |w_evt;

    // Scan downward so the lowest active index is the last one written.
    always_comb begin
        key_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (w_evt[i]) begin
                key_code = c_CW'(i);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_pop = w_pop + c_PW'(key_level[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_multi <= 1'b0;
        end else begin
            r_multi <= (w_pop > c_PW'(1));
        end
    end

    assign multi_press = r_multi;

endmodule
`default_nettype wire
